// File: rtl/bcd_seq_ctrl.sv
`timescale 1ns/1ps
// Sequential 6-bit binary to two-digit BCD converter (shift-and-add-3),
// with a two-position multiplexed 7-segment digit scan.
module bcd_seq_ctrl #(
    parameter int unsigned REFRESH_BITS = 17,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] B,
    output logic       busy,
    output logic       out_valid,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [3:0] an,
    output logic [3:0] digit
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]              r_state;
    logic [13:0]             r_shift;
    logic [2:0]              r_count;
    logic [3:0]              r_tens;
    logic [3:0]              r_ones;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic                    r_sel;

    logic [3:0]  w_tens_adj;
    logic [3:0]  w_ones_adj;
    logic [13:0] w_shifted;
    logic        w_blank;

    // Add-3 correction happens before every shift, so the final shift result
    // already holds valid BCD digits in [13:10] and [9:6].
    always_comb begin
        w_tens_adj = r_shift[13:10];
        w_ones_adj = r_shift[9:6];
        if (r_shift[13:10] >= 4'd5) begin
            w_tens_adj = r_shift[13:10] + 4'd3;
        end
        if (r_shift[9:6] >= 4'd5) begin
            w_ones_adj = r_shift[9:6] + 4'd3;
        end
        w_shifted = {w_tens_adj[2:0], w_ones_adj, r_shift[5:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift <= {8'b0, B};
                        r_count <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shifted;
                    r_count <= r_count + 3'd1;
                    if (r_count == 3'd5) begin
                        r_tens  <= w_shifted[13:10];
                        r_ones  <= w_shifted[9:6];
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_sel     <= 1'b0;
        end else begin
            r_refresh <= r_refresh + 1'b1;
            if (r_refresh == '1) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign w_blank   = BLANK_LZ && r_sel && (r_tens == 4'd0);

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == SHIFT);
    assign out_valid = (r_state == DONE);
    assign tens      = r_tens;
    assign ones      = r_ones;
    assign digit     = r_sel ? r_tens : r_ones;
    assign an        = !r_sel ? 4'b1110 : (w_blank ? 4'b1111 : 4'b1101);

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
`timescale 1ns/1ps
// Directed self-checking bench for bcd_seq_ctrl (fast refresh, leading-zero blanking on).
module tb_bcd_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] B;
    logic       busy;
    logic       out_valid;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] an;
    logic [3:0] digit;

    int n_pass  = 0;
    int n_total = 0;

    bcd_seq_ctrl #(
        .REFRESH_BITS(2),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .B        (B),
        .busy     (busy),
        .out_valid(out_valid),
        .tens     (tens),
        .ones     (ones),
        .an       (an),
        .digit    (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; B = '0;
        tick();
        tick();
        reset = 1'b0;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (tens !== 4'd0) $display("FAIL rst_tens: got %0d expected 0", tens); else n_pass++;
        n_total++; if (ones !== 4'd0) $display("FAIL rst_ones: got %0d expected 0", ones); else n_pass++;
        n_total++; if (an !== 4'b1110) $display("FAIL rst_an: got %b expected 1110", an); else n_pass++;
        n_total++; if (digit !== 4'd0) $display("FAIL rst_digit: got %0d expected 0", digit); else n_pass++;
    endtask

    // Accepts b on the next edge (k) and watches edges k..k+9.
    task automatic convert(input logic [5:0] b, input logic [3:0] prev_t, input logic [3:0] prev_o,
                           input logic [3:0] exp_t, input logic [3:0] exp_o, input string name);
        int busy_n = 0;
        int ov_n   = 0;
        int ov_at  = -1;
        int hold_bad = 0;
        logic [3:0] got_t = 4'hx;
        logic [3:0] got_o = 4'hx;
        B = b; in_valid = 1'b1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL %s_ready: got %b expected 1", name, in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (busy === 1'b1) busy_n++;
            if (out_valid === 1'b1) begin
                ov_n++;
                if (ov_at < 0) ov_at = j;
                got_t = tens; got_o = ones;
            end
            if (j < 6 && (tens !== prev_t || ones !== prev_o)) hold_bad++;
            if (j < 9) tick();
        end
        n_total++; if (busy_n !== 6) $display("FAIL %s_busy_cycles: got %0d expected 6", name, busy_n); else n_pass++;
        n_total++; if (ov_n !== 1) $display("FAIL %s_ov_cycles: got %0d expected 1", name, ov_n); else n_pass++;
        n_total++; if (ov_at !== 6) $display("FAIL %s_ov_latency: got %0d expected 6", name, ov_at); else n_pass++;
        n_total++; if (got_t !== exp_t) $display("FAIL %s_tens: got %0d expected %0d", name, got_t, exp_t); else n_pass++;
        n_total++; if (got_o !== exp_o) $display("FAIL %s_ones: got %0d expected %0d", name, got_o, exp_o); else n_pass++;
        n_total++; if (hold_bad !== 0) $display("FAIL %s_hold_during_conv: got %0d changes expected 0", name, hold_bad); else n_pass++;
        n_total++; if (tens !== exp_t || ones !== exp_o) $display("FAIL %s_hold_after: got %0d/%0d expected %0d/%0d", name, tens, ones, exp_t, exp_o); else n_pass++;
    endtask

    task automatic test_zero();
        int n_blank = 0;
        int n_ones  = 0;
        int n_other = 0;
        convert(6'd0, 4'd0, 4'd0, 4'd0, 4'd0, "b0");
        for (int j = 0; j < 8; j++) begin
            tick();
            if (an === 4'b1111 && digit === 4'd0) n_blank++;
            else if (an === 4'b1110 && digit === 4'd0) n_ones++;
            else n_other++;
        end
        n_total++; if (n_blank !== 4) $display("FAIL b0_blank_slots: got %0d expected 4", n_blank); else n_pass++;
        n_total++; if (n_ones !== 4) $display("FAIL b0_ones_slots: got %0d expected 4", n_ones); else n_pass++;
        n_total++; if (n_other !== 0) $display("FAIL b0_bad_scan: got %0d expected 0", n_other); else n_pass++;
    endtask

    task automatic test_max();
        convert(6'd63, 4'd0, 4'd0, 4'd6, 4'd3, "b63");
    endtask

    task automatic test_hold_input();
        int rdy_bad = 0;
        int keep_bad = 0;
        B = 6'd42; in_valid = 1'b1;
        tick();
        B = 6'd9;
        for (int j = 0; j < 16; j++) begin
            if (j < 6 && in_ready !== 1'b0) rdy_bad++;
            if (j == 6) begin
                n_total++; if (out_valid !== 1'b1) $display("FAIL hold_ov42: got %b expected 1", out_valid); else n_pass++;
                n_total++; if (tens !== 4'd4 || ones !== 4'd2) $display("FAIL hold_res42: got %0d/%0d expected 4/2", tens, ones); else n_pass++;
            end
            if (j == 7) begin
                n_total++; if (in_ready !== 1'b1) $display("FAIL hold_ready_k7: got %b expected 1", in_ready); else n_pass++;
            end
            if (j == 8) begin
                n_total++; if (busy !== 1'b1) $display("FAIL hold_accept_k8: got %b expected 1", busy); else n_pass++;
                in_valid = 1'b0;
            end
            if (j >= 8 && j < 14 && (tens !== 4'd4 || ones !== 4'd2)) keep_bad++;
            if (j == 14) begin
                n_total++; if (out_valid !== 1'b1) $display("FAIL hold_ov9: got %b expected 1", out_valid); else n_pass++;
                n_total++; if (tens !== 4'd0 || ones !== 4'd9) $display("FAIL hold_res9: got %0d/%0d expected 0/9", tens, ones); else n_pass++;
            end
            tick();
        end
        n_total++; if (rdy_bad !== 0) $display("FAIL hold_ready_busy: got %0d bad cycles expected 0", rdy_bad); else n_pass++;
        n_total++; if (keep_bad !== 0) $display("FAIL hold_keep42: got %0d changes expected 0", keep_bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int res = 0;
        int last_acc = -1;
        int expv;
        int sum;
        int exp_q[$];
        logic prev_rdy;
        B = 6'd0; in_valid = 1'b1;
        prev_rdy = in_ready;
        for (int cyc = 1; cyc < 64 * 8 + 20 && res < 64; cyc++) begin
            tick();
            if (prev_rdy === 1'b1 && in_valid === 1'b1) begin
                exp_q.push_back(int'(B));
                if (acc > 0) begin
                    n_total++; if (cyc - last_acc !== 8) $display("FAIL b2b_interval_%0d: got %0d expected 8", acc, cyc - last_acc); else n_pass++;
                end
                last_acc = cyc;
                acc++;
                if (acc == 64) in_valid = 1'b0;
                else B = 6'(acc);
            end
            if (out_valid === 1'b1) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                sum = int'(tens) * 10 + int'(ones);
                n_total++; if (sum !== expv) $display("FAIL b2b_value: got %0d (%0d/%0d) expected %0d", sum, tens, ones, expv); else n_pass++;
                n_total++; if (tens[3] !== 1'b0 || ones > 4'd9) $display("FAIL b2b_digit_range: got %0d/%0d expected tens<8 ones<10", tens, ones); else n_pass++;
                res++;
            end
            prev_rdy = in_ready;
        end
        in_valid = 1'b0;
        n_total++; if (acc !== 64) $display("FAIL b2b_accepts: got %0d expected 64", acc); else n_pass++;
        n_total++; if (res !== 64) $display("FAIL b2b_results: got %0d expected 64", res); else n_pass++;
        tick();
    endtask

    task automatic test_reset_abort();
        int ov_n = 0;
        int busy_n = 0;
        B = 6'd55; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1; in_valid = 1'b1; B = 6'd12;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        n_total++; if (tens !== 4'd0 || ones !== 4'd0) $display("FAIL abort_clear: got %0d/%0d expected 0/0", tens, ones); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", in_ready); else n_pass++;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (out_valid === 1'b1) ov_n++;
            if (busy === 1'b1) busy_n++;
        end
        n_total++; if (ov_n !== 0) $display("FAIL abort_no_ov: got %0d pulses expected 0", ov_n); else n_pass++;
        n_total++; if (busy_n !== 0) $display("FAIL abort_no_busy: got %0d cycles expected 0", busy_n); else n_pass++;
    endtask

    task automatic test_display();
        int bad = 0;
        int bad_run = 0;
        int trans = 0;
        int run = 0;
        int cur;
        int prev = -1;
        convert(6'd37, 4'd0, 4'd0, 4'd3, 4'd7, "b37");
        for (int j = 0; j < 20; j++) begin
            tick();
            if (an === 4'b1110 && digit === 4'd7) cur = 0;
            else if (an === 4'b1101 && digit === 4'd3) cur = 1;
            else begin cur = 2; bad++; end
            if (prev >= 0 && cur != prev) begin
                trans++;
                if (trans >= 2 && run != 4) bad_run++;
                run = 1;
            end else begin
                run++;
            end
            prev = cur;
        end
        n_total++; if (bad !== 0) $display("FAIL disp_pairs: got %0d bad samples expected 0", bad); else n_pass++;
        n_total++; if (bad_run !== 0) $display("FAIL disp_slot_len: got %0d bad slots expected 0", bad_run); else n_pass++;
        n_total++; if (trans < 4) $display("FAIL disp_toggles: got %0d expected >=4", trans); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; B = '0;
        test_reset();
        test_zero();
        test_max();
        test_hold_input();
        test_back_to_back();
        test_reset_abort();
        test_display();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 17, width of the display refresh counter; the scan slot changes once per 2^REFRESH_BITS cycles.
REQ-002 SHALL have parameter BLANK_LZ, default 1; when 1, a zero tens digit is blanked.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, value on B offered for conversion.
REQ-006 SHALL have port in_ready, output, 1, block can accept a value.
REQ-007 SHALL have port B, input, 6, binary value 0..63.
REQ-008 SHALL have port busy, output, 1, conversion in progress.
REQ-009 SHALL have port out_valid, output, 1, one-cycle pulse: new tens/ones are available.
REQ-010 SHALL have port tens, output, 4, BCD tens digit of the last completed conversion.
REQ-011 SHALL have port ones, output, 4, BCD ones digit of the last completed conversion.
REQ-012 SHALL have port an, output, 4, active-low digit enables for the 7-seg display.
REQ-013 SHALL have port digit, output, 4, BCD digit for the currently enabled display position.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 SHALL drive in_ready = (state==IDLE), busy = (state==SHIFT) and out_valid = (state==DONE), all combinationally from state.
REQ-016 SHALL accept on the edge where in_valid && in_ready: latch {8'b0,B} into a 14-bit shift register, clear the iteration count to 0, go to SHIFT.
REQ-017 SHALL ignore in_valid and B while not in IDLE; B is sampled only at acceptance.
REQ-018 SHALL, on each SHIFT edge: add 3 to each BCD nibble (bits [9:6] and [13:10]) that is >=5, then shift the whole register left by 1 and increment the count.
REQ-019 SHALL, on the 6th SHIFT edge (count==5): register tens/ones from the post-shift nibbles and go to DONE.
REQ-020 SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-021 SHALL give this timing for acceptance at edge k: tens/ones update at edge k+6; out_valid is high only in the cycle between edges k+6 and k+7; the earliest next acceptance is edge k+8; throughput is one conversion per 8 cycles.
REQ-022 SHALL hold tens/ones stable between completions, including throughout a conversion.
REQ-023 SHALL produce tens in 0..6 with tens[3] always 0, ones in 0..9, and tens*10+ones == B for all 64 inputs.
REQ-024 SHALL run a free-running refresh counter of REFRESH_BITS bits that wraps to 0 and toggles a select bit sel on wrap; sel=0 selects ones, sel=1 selects tens.
REQ-025 SHALL output: sel=0 -> an=4'b1110, digit=ones; sel=1 -> an=4'b1101, digit=tens; an[3:2] always 1.
REQ-026 SHALL, when BLANK_LZ=1, sel=1 and tens==0, drive an=4'b1111 and digit=tens (0).
REQ-027 SHALL let the display scan run independently of the FSM state; the display always shows the registered tens/ones.

Reset
REQ-028 SHALL, on an edge with reset=1, go to IDLE, clear the shift register, count, tens, ones, refresh counter and sel to 0; reset has priority over every other event.
REQ-029 SHALL give these values in the cycle after reset: in_ready=1, busy=0, out_valid=0, tens=0, ones=0, an=4'b1110, digit=0.
REQ-030 SHALL, if reset occurs in SHIFT or DONE, abort the conversion with no later out_valid pulse; a value offered with reset high is not accepted.

Verification
REQ-031 SHALL cover: reset, accept B=0 at edge k -> out_valid only in the cycle after edge k+6, tens=0, ones=0; during sel=1 slot an=4'b1111 (BLANK_LZ=1).
REQ-032 SHALL cover: B=63 -> tens=6, ones=3, out_valid high exactly 1 cycle, busy high exactly 6 cycles.
REQ-033 SHALL cover: accept B=42, then hold in_valid with B=9 throughout -> in_ready=0 during busy, result tens=4/ones=2, then B=9 accepted at edge k+8 -> tens=0, ones=9.
REQ-034 SHALL cover: all B=0..63 back-to-back with in_valid held high -> each result satisfies tens*10+ones==B, tens[3]=0, one acceptance per 8 cycles.
REQ-035 SHALL cover: accept B=55, assert reset one cycle at the 3rd SHIFT edge -> next cycle tens=0, ones=0, in_ready=1, and no out_valid pulse in the following 10 cycles.
REQ-036 SHALL cover: REFRESH_BITS=2, result 37 -> an alternates 4'b1110/4'b1101 every 4 cycles with digit 7/3.
